// File: rtl/slice_ctrl_if.sv
// DMA-side frame handshake between the receive DMA and slice_ctrl.
// The DMA side drives valid/payload; the controller drives ready.
interface slice_ctrl_if #(
  parameter int FRAME_W = 384
);
  logic               i_frame_valid;
  logic               o_frame_ready;
  logic [FRAME_W-1:0] i_frame_data;
  logic               i_frame_rate;
  logic               i_frame_last;

  modport master (
    output i_frame_valid, i_frame_data, i_frame_rate, i_frame_last,
    input  o_frame_ready
  );

  modport slave (
    input  i_frame_valid, i_frame_data, i_frame_rate, i_frame_last,
    output o_frame_ready
  );
endinterface

// File: rtl/slice_ctrl.sv
// Frame controller for the Viterbi slicer: 2-entry ping-pong buffer, per-frame step count, decoder backpressure.
// Optional statistics counters are built only when SLICE_CTRL_STATS_EN is defined.
module slice_ctrl #(
  parameter int FRAME_W = 384
) (
  input  logic               clk,
  input  logic               rst,
  slice_ctrl_if.slave        fr,
  input  logic               i_dec_ready,
  output logic [FRAME_W-1:0] o_data_frame,
  output logic               o_code_rate,
  output logic               o_en_s,
  output logic               o_slice_rst,
  output logic               o_frame_start,
  output logic               o_msg_done,
  output logic               o_busy,
  output logic [15:0]        o_frame_cnt,
  output logic [15:0]        o_stall_cnt
);
  localparam logic       CODE_RATE_2 = 1'b0;
  localparam logic [6:0] N_RATE2     = 7'(FRAME_W / 4);
  localparam logic [6:0] N_RATE3     = 7'(FRAME_W / 6);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] buf_data [2];
  logic [1:0]         buf_rate, buf_last;
  logic               wr_ptr, rd_ptr;
  logic [1:0]         occ, occ_nxt;
  logic [6:0]         step, n_steps;
  logic               push, pop;

  assign fr.o_frame_ready = (occ < 2'd2);
  assign push             = fr.i_frame_valid & fr.o_frame_ready;

  assign o_data_frame = buf_data[rd_ptr];
  assign o_code_rate  = buf_rate[rd_ptr];
  assign n_steps      = (o_code_rate == CODE_RATE_2) ? N_RATE2 : N_RATE3;
  assign pop          = o_en_s && (step == n_steps - 7'd1);
  assign occ_nxt      = occ + 2'(push) - 2'(pop);

  // Payload storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= fr.i_frame_data;
      buf_rate[wr_ptr] <= fr.i_frame_rate;
      buf_last[wr_ptr] <= fr.i_frame_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
      step   <= 7'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ <= occ_nxt;
      if (state == LOAD)  step <= 7'd0;
      else if (o_en_s)    step <= step + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A frame pushed on the pop edge counts as buffered, so it chains straight into LOAD.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (occ != 2'd0) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
        if (pop) begin
          if (buf_last[rd_ptr])     state_nxt = DONE;
          else if (occ_nxt != 2'd0) state_nxt = LOAD;
          else                      state_nxt = IDLE;
        end
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_en_s        = (state == RUN) & i_dec_ready;
    o_frame_start = (state == LOAD);
    o_msg_done    = (state == DONE);
    o_slice_rst   = rst & (state != LOAD);
    o_busy        = (state != IDLE) | (occ != 2'd0);
  end

`ifdef SLICE_CTRL_STATS_EN
  logic [15:0] frame_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (pop && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (state == RUN && !i_dec_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt;
  assign o_stall_cnt = stall_cnt;
`else
  assign o_frame_cnt = 16'd0;
  assign o_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_slice_ctrl.sv
// Scoreboard bench for slice_ctrl: pushed frames queue their expected steps; a monitor
// tracks each frame from its start pulse through N steps and the end-of-frame sequence.
module tb_slice_ctrl;
  localparam int   FW = 384;
  localparam logic R2 = 1'b0;
  localparam logic R3 = 1'b1;
  localparam int   P_IDLE = 0, P_RUN = 1, P_GAP = 2, P_DONE = 3, P_POST = 4;

  typedef struct {
    logic [FW-1:0] data;
    logic          rate;
    logic          last;
  } frm_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dec_ready = 1'b0;
  logic [FW-1:0] data_frame;
  logic          code_rate, en_s, slice_rst, frame_start, msg_done, busy;
  logic [15:0]   frame_cnt, stall_cnt;

  slice_ctrl_if #(.FRAME_W(FW)) fif();

  slice_ctrl #(.FRAME_W(FW)) dut (
    .clk(clk), .rst(rst), .fr(fif), .i_dec_ready(dec_ready),
    .o_data_frame(data_frame), .o_code_rate(code_rate), .o_en_s(en_s),
    .o_slice_rst(slice_rst), .o_frame_start(frame_start), .o_msg_done(msg_done),
    .o_busy(busy), .o_frame_cnt(frame_cnt), .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  frm_t exp_q[$];
  frm_t cur;
  int   ph = P_IDLE, steps = 0, run_cyc = 0, last_run_cyc = 0, pend = 0;
  int   qs1 = 0, qs2 = 0, occ_m = 0;
  int   stall_m = 0, fcnt_m = 0, fs_cnt = 0, msg_cnt = 0;
  bit   prev_idle = 1'b1, cur_idle;
  int   rdy_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nsteps(input logic rate);
    return (rate == R2) ? FW / 4 : FW / 6;
  endfunction

  function automatic frm_t rnd_frame(input logic rate, input logic last);
    frm_t f;
    for (int i = 0; i < FW / 32; i++) f.data[i*32 +: 32] = $urandom;
    f.rate = rate;
    f.last = last;
    return f;
  endfunction

  task automatic start_frame();
    chk("load_has_frame", int'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) cur = exp_q.pop_front();
    fs_cnt++;
    steps   = 0;
    run_cyc = 0;
    ph      = P_RUN;
  endtask

  // Monitor / scoreboard: samples one time unit after the falling edge.
  initial forever begin
    @(negedge clk); #1;
    if (!rst) begin
      chk("rst_slice_rst", int'(slice_rst), 0);
      exp_q.delete();
      ph = P_IDLE; steps = 0; qs1 = 0; qs2 = 0; prev_idle = 1'b1;
      stall_m = 0; fcnt_m = 0;
    end else begin
      occ_m = qs1 + ((ph == P_RUN) ? 1 : 0);
      chk("frame_ready", int'(fif.o_frame_ready), int'(occ_m < 2));
      chk("slice_rst", int'(slice_rst), int'(!frame_start));
      cur_idle = 1'b0;
      case (ph)
        P_IDLE: begin
          chk("idle_quiet", int'({en_s, msg_done}), 0);
          chk("idle_to_load", int'(frame_start), int'(prev_idle && qs2 != 0));
          if (frame_start) start_frame();
          else cur_idle = 1'b1;
        end
        P_RUN: begin
          run_cyc++;
          chk("run_no_pulse", int'({frame_start, msg_done}), 0);
          chk("en_gate", int'(en_s), int'(dec_ready));
          if (!dec_ready) stall_m++;
          if (en_s) begin
            chkd("data", data_frame, cur.data);
            chk("rate", int'(code_rate), int'(cur.rate));
            steps++;
            if (steps == nsteps(cur.rate)) begin
              fcnt_m++;
              last_run_cyc = run_cyc;
              pend = exp_q.size();
              ph = cur.last ? P_DONE : P_GAP;
            end
          end
        end
        P_GAP: begin
          chk("gap_load", int'(frame_start), int'(pend != 0));
          chk("gap_quiet", int'({en_s, msg_done}), 0);
          if (frame_start) start_frame();
          else begin cur_idle = 1'b1; ph = P_IDLE; end
        end
        P_DONE: begin
          chk("msg_done", int'(msg_done), 1);
          chk("done_quiet", int'({en_s, frame_start}), 0);
          if (msg_done) msg_cnt++;
          ph = P_POST;
        end
        default: begin
          chk("post_idle", int'({en_s, frame_start, msg_done}), 0);
          cur_idle = 1'b1;
          ph = P_IDLE;
        end
      endcase
      chk("busy", int'(busy), int'(!cur_idle || occ_m != 0));
      qs2 = qs1;
      qs1 = exp_q.size();
      prev_idle = cur_idle;
    end
  end

  // Decoder-ready driver: 0 = always ready, 1 = random, 2 = 1,0,1,0 from the first RUN cycle.
  initial begin
    bit fs_seen;
    forever begin
      @(negedge clk); #1;
      fs_seen = frame_start;
      @(posedge clk); #1;
      case (rdy_mode)
        0:       dec_ready = 1'b1;
        1:       dec_ready = ($urandom_range(0, 3) != 0);
        default: dec_ready = fs_seen ? 1'b1 : ~dec_ready;
      endcase
    end
  end

  // Offers f and leaves valid high; returns one cycle past the accepting edge.
  task automatic push(input frm_t f, output int waits);
    waits = 0;
    fif.i_frame_valid = 1'b1;
    fif.i_frame_data  = f.data;
    fif.i_frame_rate  = f.rate;
    fif.i_frame_last  = f.last;
    forever begin
      @(negedge clk);
      if (fif.o_frame_ready) begin
        exp_q.push_back(f);
        break;
      end
      waits++;
      if (waits > 2000) begin
        checks++; errors++;
        $display("FAIL push_timeout: got no ready expected ready within 2000 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input bit toggle_rate, input int limit);
    int n = 0;
    forever begin
      @(posedge clk); #1;
      if (toggle_rate) fif.i_frame_rate = ~fif.i_frame_rate;
      if (ph == P_IDLE && exp_q.size() == 0 && !busy) break;
      n++;
      if (n > limit) begin
        checks++; errors++;
        $display("FAIL idle_timeout: got busy expected idle within %0d cycles", limit);
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, fs0, m0, st0, n;
    frm_t f;
    fif.i_frame_valid = 1'b0;
    fif.i_frame_data  = '0;
    fif.i_frame_rate  = R2;
    fif.i_frame_last  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en_s", int'(en_s), 0);
    chk("rst_start", int'(frame_start), 0);
    chk("rst_msg", int'(msg_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(fif.o_frame_ready), 1);
    @(posedge clk); #1;

    // Single rate-1/2 last frame: LOAD two cycles after the push
    fs0 = fs_cnt; m0 = msg_cnt;
    push(rnd_frame(R2, 1'b1), w);
    fif.i_frame_valid = 1'b0;
    @(negedge clk);
    chk("t1_no_early_load", int'(frame_start), 0);
    @(negedge clk);
    chk("t1_load", int'(frame_start), 1);
    wait_idle(1'b0, 500);
    chk("t1_one_start", fs_cnt - fs0, 1);
    chk("t1_one_msg", msg_cnt - m0, 1);
    chk("t1_run_cycles", last_run_cyc, 96);

    // Single rate-1/3 last frame
    push(rnd_frame(R3, 1'b1), w);
    fif.i_frame_valid = 1'b0;
    wait_idle(1'b0, 500);
    chk("t2_run_cycles", last_run_cyc, 64);

    // Three back-to-back frames, valid held high
    fs0 = fs_cnt; m0 = msg_cnt;
    push(rnd_frame(R2, 1'b0), w);
    push(rnd_frame(R2, 1'b0), w);
    chk("t3_second_no_wait", w, 0);
    push(rnd_frame(R2, 1'b1), w);
    chk("t3_ready_low_cycles", w, 97);
    fif.i_frame_valid = 1'b0;
    wait_idle(1'b0, 1000);
    chk("t3_starts", fs_cnt - fs0, 3);
    chk("t3_msgs", msg_cnt - m0, 1);

    // Backpressure 1,0,1,0 on a rate-1/2 frame
    rdy_mode = 2;
    st0 = stall_m;
    push(rnd_frame(R2, 1'b1), w);
    fif.i_frame_valid = 1'b0;
    wait_idle(1'b0, 1000);
    chk("t4_run_cycles", last_run_cyc, 191);
    chk("t4_stalls_model", stall_m - st0, 95);
`ifdef SLICE_CTRL_STATS_EN
    chk("t4_stall_cnt", int'(stall_cnt), 95);
`else
    chk("t4_stall_cnt", int'(stall_cnt), 0);
`endif
    rdy_mode = 0;

    // Rate captured at push; i_frame_rate toggles while A runs
    push(rnd_frame(R2, 1'b0), w);
    push(rnd_frame(R3, 1'b1), w);
    fif.i_frame_valid = 1'b0;
    wait_idle(1'b1, 1000);
    chk("t5_b_run_cycles", last_run_cyc, 64);

    // Reset at step 40 of a running frame with another buffered
    m0 = msg_cnt;
    push(rnd_frame(R2, 1'b0), w);
    push(rnd_frame(R2, 1'b0), w);
    fif.i_frame_valid = 1'b0;
    n = 0;
    while (!(ph == P_RUN && steps >= 40) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reached_step40", int'(steps >= 40), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_slice_rst", int'(slice_rst), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_en_s", int'(en_s), 0);
    chk("t6_msg", int'(msg_done), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_slice_rst_held", int'(slice_rst), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_ready", int'(fif.o_frame_ready), 1);
    chk("t6_frame_cnt", int'(frame_cnt), 0);
    chk("t6_stall_cnt", int'(stall_cnt), 0);
    @(posedge clk); #1;
    push(rnd_frame(R2, 1'b1), w);
    fif.i_frame_valid = 1'b0;
    wait_idle(1'b0, 500);
    chk("t6_full_run", last_run_cyc, 96);
    chk("t6_msgs", msg_cnt - m0, 1);

    // Randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 3);
      if (n != 0) begin
        fif.i_frame_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
      end
      f = rnd_frame(1'($urandom_range(0, 1)), (i == 24) || ($urandom_range(0, 3) == 0));
      push(f, w);
    end
    fif.i_frame_valid = 1'b0;
    wait_idle(1'b0, 20000);
    rdy_mode = 0;
    @(negedge clk);
`ifdef SLICE_CTRL_STATS_EN
    chk("end_frame_cnt", int'(frame_cnt), fcnt_m);
    chk("end_stall_cnt", int'(stall_cnt), stall_m);
`else
    chk("end_frame_cnt", int'(frame_cnt), 0);
    chk("end_stall_cnt", int'(stall_cnt), 0);
`endif
    chk("end_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/slice_ctrl.md
# slice_ctrl

Frame-level controller for the `slice` datapath in the Viterbi receive path. Accepts 384-bit received frames from the DMA side over a valid/ready handshake into a two-entry ping-pong buffer. Presents one frame at a time to the slicer, reloads the slicer's bit pointer between frames, and gates slicing steps against decoder backpressure. Signals frame start and message completion to the decoder control.

## Interface
- `FRAME_W`, 384: frame width in bits. Must be divisible by 4 and 6.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active-low.
- `i_frame_valid`, in, 1: a frame is offered by the DMA side.
- `o_frame_ready`, out, 1: the buffer can accept a frame.
- `i_frame_data`, in, FRAME_W: frame payload. The MSB is the first received bit.
- `i_frame_rate`, in, 1: code rate of the offered frame (`CODE_RATE_2` / `CODE_RATE_3` from param_def.sv).
- `i_frame_last`, in, 1: the offered frame is the last one of the message.
- `i_dec_ready`, in, 1: the decoder can consume one slice step this cycle.
- `o_data_frame`, out, FRAME_W: frame driven into the slicer's `i_data_frame`.
- `o_code_rate`, out, 1: code rate driven into the slicer's `i_code_rate`.
- `o_en_s`, out, 1: slicer step enable.
- `o_slice_rst`, out, 1: active-low synchronous reset to the slicer. It reloads the slicer's bit pointer.
- `o_frame_start`, out, 1: one-cycle pulse when a frame is loaded.
- `o_msg_done`, out, 1: one-cycle pulse after the last step of a last-flagged frame.
- `o_busy`, out, 1: the controller is not in IDLE, or the buffer is non-empty.
- `o_frame_cnt`, out, 16: frames completed (see Configuration).
- `o_stall_cnt`, out, 16: RUN cycles with `i_dec_ready`=0 (see Configuration).

## Operation
- **Buffer.** Two entries. Each entry holds `{data, rate, last}`. There is a 1-bit write pointer, a 1-bit read pointer, and a 2-bit occupancy `occ` (0..2).
  - `o_frame_ready` = (`occ` < 2). It is decoded from registered `occ` and does not depend on `i_frame_valid`.
  - A push occurs on `i_frame_valid` & `o_frame_ready`. The push writes the entry at the write pointer, then toggles the write pointer.
  - A pop occurs on the final step in RUN. The pop toggles the read pointer.
  - Push and pop in the same cycle leave `occ` unchanged.
  - There is no same-cycle bypass. A slot freed by a pop is visible through `o_frame_ready` the next cycle.
- **Datapath.** `o_data_frame` and `o_code_rate` come from the entry at the read pointer. They are stable for the whole LOAD and RUN of that frame.
  - Code rate is captured per frame at push. Changes to `i_frame_rate` while a frame is held have no effect on that frame.
- **Steps per frame (N).** `FRAME_W`/4 for `CODE_RATE_2` (96). `FRAME_W`/6 for `CODE_RATE_3` (64).
  - The step counter is 7 bits, cleared in LOAD, and incremented on each cycle with `o_en_s`=1.
  - The controller counts steps itself and does not depend on the slicer's `o_ood`.
- **FSM states.**
  - **IDLE:** `o_en_s`=0. If `occ`≠0, go to LOAD.
  - **LOAD:** one cycle. `o_slice_rst`=0, `o_frame_start`=1, step counter cleared. Go to RUN.
  - **RUN:** `o_en_s` = `i_dec_ready`. On the cycle with `o_en_s`=1 and step = N−1, pop the entry. Then:
    - if the entry's last flag is set, go to DONE;
    - else if `occ` after the pop is ≠0, go to LOAD;
    - else go to IDLE.
  - **DONE:** one cycle. `o_msg_done`=1. Go to IDLE. If `occ`≠0, the next frame starts via IDLE.
- **Outputs during reset and in non-LOAD states.**
  - `o_slice_rst` = `rst` & (state≠LOAD), so the slicer is held in reset while `rst`=0.
  - `o_frame_start` and `o_msg_done` are decoded from state and are never asserted in two consecutive cycles.
- **Reset values** (`rst`=0 sampled at an edge):
  - state IDLE, `occ`=0, both pointers 0, step counter 0, counters 0;
  - `o_frame_ready`=1 (when `rst` is high again), `o_en_s`=0, `o_slice_rst`=0, `o_frame_start`=0, `o_msg_done`=0, `o_busy`=0;
  - `o_data_frame` = entry 0 contents, which are don't-care.
- **Reset mid-frame.** Buffered frames are discarded and no `o_msg_done` is produced. The DMA side must re-send the frames.

## Timing
- If a push occurs at edge E into an empty, IDLE controller: `occ`=1 after E, LOAD in the 2nd cycle after E, and the first possible `o_en_s` in the 3rd cycle.
- Slicer outputs are valid in the same cycle as `o_en_s`. The slicer advances its pointer at the edge ending that cycle.
- Frame-to-frame gap with the next frame already buffered: exactly one non-stepping cycle (LOAD).
- After a last-flagged frame: DONE, then IDLE, then LOAD. That is three non-stepping cycles.
- With `i_dec_ready` held at 1, a frame takes exactly N RUN cycles.

## Configuration
- `SLICE_CTRL_STATS_EN` defined:
  - `o_frame_cnt` increments on each pop and saturates at 16'hFFFF.
  - `o_stall_cnt` increments on each RUN cycle with `i_dec_ready`=0 and saturates.
  - Both counters clear only on reset.
- `SLICE_CTRL_STATS_EN` undefined: no counter registers are built, and both ports are tied to 0.

## Test plan
- **Single frame, `CODE_RATE_2`, last=1, `i_dec_ready`=1:** exactly one `o_frame_start`, then 96 consecutive `o_en_s` cycles, `o_msg_done` in the cycle after the 96th, and `o_busy`=0 two cycles later.
- **Single frame, `CODE_RATE_3`, last=1:** 64 `o_en_s` cycles. `o_slice_rst`=0 only in the LOAD cycle.
- **Three back-to-back frames (last on frame 3), with `i_frame_valid` held high:**
  - `o_frame_ready` drops after the second push and rises the cycle after frame 1's pop;
  - exactly one LOAD cycle separates frames 1 and 2.
- **Backpressure on a rate-1/2 frame, `i_dec_ready` toggling 1,0,1,0:** `o_en_s` asserts only when ready, 96 steps total, 191 RUN cycles, and `o_stall_cnt`=95 when the macro is defined.
- **Rate capture:** frame A pushed with `CODE_RATE_2`, frame B with `CODE_RATE_3`, and `i_frame_rate` toggling during A. A takes 96 steps and B takes 64, with `o_code_rate` constant within each frame.
- **Reset at RUN step 40 with 2 frames buffered:**
  - next cycle: IDLE, `occ`=0, `o_en_s`=0, `o_slice_rst`=0, no `o_msg_done`;
  - after reset release: `o_frame_ready`=1, and a new frame runs a full 96 steps.
